// File: rtl/adc_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_pkg
// Description : Shared types and constants for the ADC triggered snapshot
//               buffer: controller state encoding, beat/timestamp widths and
//               a helper that tells whether a state records input beats.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_capture_pkg;

    localparam int ADC_BEAT_WIDTH = 128;
    localparam int TS_WIDTH       = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        ARMED   = 3'd2,
        POST    = 3'd3,
        READOUT = 3'd4,
        DONE    = 3'd5
    } cap_state_t;

    // States in which incoming ADC beats are written into the ring.
    function automatic logic is_recording(input cap_state_t s);
        return (s == FILL) || (s == ARMED) || (s == POST);
    endfunction

endpackage : adc_capture_pkg
`default_nettype wire

// File: rtl/adc_capture_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_buffer_if
// Description : AXI4-Stream style beat bundle (tdata/tvalid/tready/tlast).
//               master : drives tdata/tvalid/tlast, receives tready
//               slave  : receives tdata/tvalid/tlast, drives tready
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_capture_buffer_if
    import adc_capture_pkg::*;
#(
    parameter int DATA_WIDTH = ADC_BEAT_WIDTH
) ();

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);

endinterface : adc_capture_buffer_if
`default_nettype wire

// File: rtl/adc_capture_ram.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_ram
// Description : Simple dual-port RAM, DATA_WIDTH x 2**ADDR_BITS, one write
//               port and one read port with a registered (1-cycle) read.
//               Written without reset so it maps onto block RAM / URAM.
// Ports       : clk      - clock
//               wr_en    - write strobe, wr_addr / wr_data
//               rd_en    - read strobe, rd_addr; rd_data valid next cycle
// Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_ram #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_BITS  = 10
) (
    input  wire logic                  clk,
    input  wire logic                  wr_en,
    input  wire logic [ADDR_BITS-1:0]  wr_addr,
    input  wire logic [DATA_WIDTH-1:0] wr_data,
    input  wire logic                  rd_en,
    input  wire logic [ADDR_BITS-1:0]  rd_addr,
    output logic      [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule : adc_capture_ram
`default_nettype wire

// File: rtl/adc_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_buffer
// Description : Triggered snapshot buffer. After arm it records ADC beats
//               into a circular RAM, waits for a full pre-trigger history,
//               captures POST_BEATS more beats after a trigger rising edge,
//               then replays the whole ring oldest-first on m_axis with
//               backpressure and TLAST on the final beat.
// Ports       : aclk, aresetn (async, active-low)
//               arm       - one-cycle pulse, starts a capture (IDLE only)
//               trig_in   - synchronous level trigger, rising edge used
//               s_axis    - ADC input stream (tready tied high)
//               m_axis    - snapshot readout stream
//               busy      - high whenever not IDLE
//               done      - one-cycle pulse after the last beat is accepted
//               overflow  - sticky: trigger edge seen during FILL
// Options     : ADC_CAPTURE_TIMESTAMP_EN - adds a free-running 64-bit cycle
//               counter; the value at the trigger edge is sent as a header
//               beat ahead of the data (snapshot becomes DEPTH+1 beats).
// Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_buffer
    import adc_capture_pkg::*;
#(
    parameter int DATA_WIDTH = ADC_BEAT_WIDTH,
    parameter int ADDR_BITS  = 10,
    parameter int POST_BEATS = 256
) (
    input  wire logic             aclk,
    input  wire logic             aresetn,
    input  wire logic             arm,
    input  wire logic             trig_in,
    adc_capture_buffer_if.slave   s_axis,
    adc_capture_buffer_if.master  m_axis,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int CW    = ADDR_BITS + 1;
`ifdef ADC_CAPTURE_TIMESTAMP_EN
    localparam int SNAP_BEATS = DEPTH + 1;
`else
    localparam int SNAP_BEATS = DEPTH;
`endif
    localparam logic [CW-1:0] FILL_TARGET = CW'(DEPTH - POST_BEATS);
    localparam logic [CW-1:0] POST_TARGET = CW'(POST_BEATS);
    localparam logic [CW-1:0] SNAP_TOTAL  = CW'(SNAP_BEATS);
    localparam logic [CW-1:0] LAST_IDX    = CW'(SNAP_BEATS - 1);

    if ((POST_BEATS < 1) || (POST_BEATS > DEPTH - 1)) begin : g_bad_post_beats
        $error("adc_capture_buffer: POST_BEATS must lie in 1..DEPTH-1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    cap_state_t             state_q, state_d;
    logic [ADDR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          fill_cnt_q, fill_cnt_d;
    logic [CW-1:0]          post_cnt_q, post_cnt_d;
    logic [CW-1:0]          rd_cnt_q, rd_cnt_d;
    logic                   trig_q;
    logic                   overflow_q, overflow_d;

    // Readout pipeline: pend = read issued last cycle (data on RAM output),
    // out = registered stream output, skid = overflow slot for a stall.
    logic                   pend_valid_q, pend_valid_d;
    logic                   pend_last_q, pend_last_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic                   skid_valid_q, skid_valid_d;
    logic                   skid_last_q, skid_last_d;
    logic [DATA_WIDTH-1:0]  skid_data_q, skid_data_d;

    logic                   trig_edge;
    logic                   wr_en;
    logic                   pop;
    logic [1:0]             occ;
    logic                   rd_issue;
    logic                   hdr_issue;
    logic                   ram_rd_en;
    logic [DATA_WIDTH-1:0]  ram_rd_data;
    logic [DATA_WIDTH-1:0]  src_data;
    logic                   unused_s_tlast;

`ifdef ADC_CAPTURE_TIMESTAMP_EN
    if (DATA_WIDTH < TS_WIDTH) begin : g_bad_ts_width
        $error("adc_capture_buffer: DATA_WIDTH too narrow for timestamp header");
    end

    logic [TS_WIDTH-1:0]    ts_cnt_q;
    logic [TS_WIDTH-1:0]    ts_latch_q, ts_latch_d;
    logic                   pend_hdr_q, pend_hdr_d;
`endif

    assign trig_edge      = trig_in & ~trig_q;
    assign wr_en          = s_axis.tvalid & is_recording(state_q);
    assign pop            = out_valid_q & m_axis.tready;
    assign unused_s_tlast = s_axis.tlast;

    // Entries held next cycle must not exceed the two output slots, so a
    // new read is issued only if at most one entry remains after this pop.
    assign occ = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, pend_valid_q};
    assign rd_issue = (state_q == READOUT) && (rd_cnt_q != SNAP_TOTAL)
                      && ((occ - {1'b0, pop}) <= 2'd1);

`ifdef ADC_CAPTURE_TIMESTAMP_EN
    assign hdr_issue = rd_issue && (rd_cnt_q == '0);
    assign src_data  = pend_hdr_q ? {{(DATA_WIDTH-TS_WIDTH){1'b0}}, ts_latch_q}
                                  : ram_rd_data;
`else
    assign hdr_issue = 1'b0;
    assign src_data  = ram_rd_data;
`endif
    assign ram_rd_en = rd_issue & ~hdr_issue;

    adc_capture_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_ram (
        .clk     (aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (s_axis.tdata),
        .rd_en   (ram_rd_en),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_cnt_d   = fill_cnt_q;
        post_cnt_d   = post_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        overflow_d   = overflow_q;
        pend_valid_d = 1'b0;
        pend_last_d  = 1'b0;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_last_d  = skid_last_q;
        skid_data_d  = skid_data_q;
`ifdef ADC_CAPTURE_TIMESTAMP_EN
        ts_latch_d   = ts_latch_q;
        pend_hdr_d   = 1'b0;
`endif

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d    = FILL;
                    fill_cnt_d = '0;
                    overflow_d = 1'b0;
                end
            end
            FILL: begin
                if (trig_edge) begin
                    overflow_d = 1'b1;
                end
                if (wr_en) begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (fill_cnt_d == FILL_TARGET) begin
                        state_d = ARMED;
                    end
                end
            end
            ARMED: begin
                if (trig_edge) begin
                    state_d    = POST;
                    post_cnt_d = '0;
`ifdef ADC_CAPTURE_TIMESTAMP_EN
                    ts_latch_d = ts_cnt_q;
`endif
                end
            end
            POST: begin
                if (wr_en) begin
                    post_cnt_d = post_cnt_q + 1'b1;
                    if (post_cnt_d == POST_TARGET) begin
                        state_d  = READOUT;
                        // Slot about to be overwritten next holds the oldest beat.
                        rd_ptr_d = wr_ptr_d;
                        rd_cnt_d = '0;
                    end
                end
            end
            READOUT: begin
                if (rd_issue) begin
                    rd_cnt_d     = rd_cnt_q + 1'b1;
                    pend_valid_d = 1'b1;
                    pend_last_d  = (rd_cnt_q == LAST_IDX);
`ifdef ADC_CAPTURE_TIMESTAMP_EN
                    pend_hdr_d   = hdr_issue;
`endif
                    if (ram_rd_en) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
                if (pop && out_last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Output / skid movement. Older data (skid) always leaves first.
        if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_last_d   = skid_last_q;
                skid_valid_d = pend_valid_q;
                skid_data_d  = src_data;
                skid_last_d  = pend_last_q;
            end else begin
                out_valid_d = pend_valid_q;
                out_last_d  = pend_valid_q & pend_last_q;
                if (pend_valid_q) begin
                    out_data_d = src_data;
                end
            end
        end else if (pend_valid_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = src_data;
            skid_last_d  = pend_last_q;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_cnt_q   <= '0;
            post_cnt_q   <= '0;
            rd_cnt_q     <= '0;
            trig_q       <= 1'b0;
            overflow_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_last_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_cnt_q   <= fill_cnt_d;
            post_cnt_q   <= post_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            trig_q       <= trig_in;
            overflow_q   <= overflow_d;
            pend_valid_q <= pend_valid_d;
            pend_last_q  <= pend_last_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_last_q  <= skid_last_d;
            skid_data_q  <= skid_data_d;
        end
    end

`ifdef ADC_CAPTURE_TIMESTAMP_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ts_cnt_q   <= '0;
            ts_latch_q <= '0;
            pend_hdr_q <= 1'b0;
        end else begin
            ts_cnt_q   <= ts_cnt_q + 1'b1;
            ts_latch_q <= ts_latch_d;
            pend_hdr_q <= pend_hdr_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axis.tready = 1'b1;
    assign m_axis.tvalid = out_valid_q;
    assign m_axis.tdata  = out_data_q;
    assign m_axis.tlast  = out_last_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign overflow      = overflow_q;

endmodule : adc_capture_buffer
`default_nettype wire

// File: tb/tb_adc_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_capture_buffer
// Description : Self-checking bench for adc_capture_buffer (DEPTH=16,
//               POST_BEATS=4). Input data is a running beat index so the
//               expected snapshot follows directly from the trigger beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_capture_buffer;
    import adc_capture_pkg::*;

    localparam int DW    = 128;
    localparam int AB    = 4;
    localparam int DEPTH = 16;
    localparam int POST  = 4;
`ifdef ADC_CAPTURE_TIMESTAMP_EN
    localparam int SNAP  = DEPTH + 1;
`else
    localparam int SNAP  = DEPTH;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic arm;
    logic trig_in;
    logic busy;
    logic done;
    logic overflow;

    adc_capture_buffer_if #(.DATA_WIDTH(DW)) s_if ();
    adc_capture_buffer_if #(.DATA_WIDTH(DW)) m_if ();

    int              n_cmp;
    int              n_fail;
    int              beat_idx;
    longint unsigned cyc;

    adc_capture_buffer #(
        .DATA_WIDTH (DW),
        .ADDR_BITS  (AB),
        .POST_BEATS (POST)
    ) dut (
        .aclk     (clk),
        .aresetn  (rst_n),
        .arm      (arm),
        .trig_in  (trig_in),
        .s_axis   (s_if),
        .m_axis   (m_if),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one cycle; inputs change and outputs are sampled 1 unit after
    // the rising edge. cyc counts rising edges seen out of reset.
    task automatic step();
        @(posedge clk);
        if (rst_n) cyc++;
        #1;
        beat_idx++;
        s_if.tdata = DW'(beat_idx);
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        arm         = 1'b0;
        trig_in     = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b1;
        beat_idx    = 0;
        cyc         = 0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", m_if.tvalid); end
        n_cmp++; if (m_if.tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b expected 0", m_if.tlast); end
        n_cmp++; if (m_if.tdata !== '0) begin n_fail++; $display("FAIL reset_tdata: got %0h expected 0", m_if.tdata); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_cmp++; if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL s_tready: got %b expected 1", s_if.tready); end
        rst_n = 1'b1;
        cyc   = 0;
        repeat (3) step();
        // A trigger edge in IDLE has no effect.
        trig_in = 1'b1;
        step();
        step();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_trig_busy: got %b expected 0", busy); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL idle_trig_overflow: got %b expected 0", overflow); end
        trig_in = 1'b0;
        step();
    endtask

    // Optionally arm, raise the trigger trig_delay cycles later, then drain
    // and check the snapshot against the expected beat window.
    task automatic test_snapshot(input bit do_arm, input int trig_delay,
                                 input bit rand_ready, input string tag);
        int              e_beat;
        longint unsigned e_cyc;
        logic [DW-1:0]   exp_q[$];
        logic [DW-1:0]   got_d[$];
        bit              got_l[$];
        int              first_off, last_off, done_cnt, done_off, stable_err;
        bit              prev_stall, finished;
        logic [DW-1:0]   prev_data;
        logic            prev_last;

        if (do_arm) begin
            arm = 1'b1;
            step();
            arm = 1'b0;
            repeat (trig_delay - 1) step();
        end else begin
            repeat (trig_delay) step();
        end
        trig_in = 1'b1;
        e_beat  = beat_idx;
        e_cyc   = cyc;

`ifdef ADC_CAPTURE_TIMESTAMP_EN
        exp_q.push_back(DW'(e_cyc));
`endif
        for (int k = DEPTH - 1; k >= 0; k--) exp_q.push_back(DW'(e_beat + POST - k));

        first_off = -1; last_off = -1; done_cnt = 0; done_off = -1;
        stable_err = 0; prev_stall = 1'b0; finished = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        for (int c = 0; c < 400 && !finished; c++) begin
            if (c == 1) trig_in = 1'b0;
            m_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall && (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_data
                               || m_if.tlast !== prev_last)) stable_err++;
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_data  = m_if.tdata;
            prev_last  = m_if.tlast;
            if (m_if.tvalid && first_off < 0) first_off = c;
            if (m_if.tvalid && m_if.tready) begin
                got_d.push_back(m_if.tdata);
                got_l.push_back(m_if.tlast);
                if (m_if.tlast) last_off = c;
            end
            if (done) begin
                done_cnt++;
                done_off = c;
            end
            if (last_off >= 0 && c >= last_off + 3) finished = 1'b1;
            step();
        end
        m_if.tready = 1'b1;

        n_cmp++; if (!finished) begin n_fail++; $display("FAIL %s timeout: got %0d beats, expected completion", tag, got_d.size()); end
        n_cmp++; if (got_d.size() !== SNAP) begin n_fail++; $display("FAIL %s beat_count: got %0d expected %0d", tag, got_d.size(), SNAP); end
        for (int i = 0; i < got_d.size() && i < SNAP; i++) begin
            n_cmp++; if (got_d[i] !== exp_q[i]) begin n_fail++; $display("FAIL %s data[%0d]: got %0h expected %0h", tag, i, got_d[i], exp_q[i]); end
            n_cmp++; if (got_l[i] !== (i == SNAP - 1)) begin n_fail++; $display("FAIL %s tlast[%0d]: got %b expected %b", tag, i, got_l[i], (i == SNAP - 1)); end
        end
        n_cmp++; if (first_off !== POST + 3) begin n_fail++; $display("FAIL %s first_valid_latency: got %0d expected %0d", tag, first_off, POST + 3); end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL %s done_pulses: got %0d expected 1", tag, done_cnt); end
        n_cmp++; if (done_off !== last_off + 1) begin n_fail++; $display("FAIL %s done_timing: got %0d expected %0d", tag, done_off, last_off + 1); end
        n_cmp++; if (stable_err !== 0) begin n_fail++; $display("FAIL %s stall_stability: got %0d changes expected 0", tag, stable_err); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after: got %b expected 0", tag, busy); end
        if (!rand_ready) begin
            n_cmp++; if (last_off - first_off !== SNAP - 1) begin n_fail++; $display("FAIL %s throughput: got span %0d expected %0d", tag, last_off - first_off, SNAP - 1); end
        end
    endtask

    task automatic test_basic();
        test_snapshot(1'b1, 30, 1'b0, "basic");
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_backpressure();
        for (int it = 0; it < 3; it++) begin
            test_snapshot(1'b1, int'($urandom_range(13, 40)), 1'b1, $sformatf("bp%0d", it));
        end
    endtask

    task automatic test_overflow();
        arm = 1'b1;
        step();
        arm = 1'b0;
        repeat (4) step();
        trig_in = 1'b1;                 // 5 beats after arm, still filling
        step();
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        trig_in = 1'b0;
        step();
        arm = 1'b1;                     // arm while busy must be ignored
        step();
        arm = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_arm_busy: got %b expected 1", overflow); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovf_busy: got %b expected 1", busy); end
        test_snapshot(1'b0, 15, 1'b0, "ovf_capture");
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        arm = 1'b1;
        step();
        arm = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
        test_snapshot(1'b0, 20, 1'b0, "ovf_rearm");
    endtask

    task automatic test_arm_trig_same_cycle();
        arm     = 1'b1;
        trig_in = 1'b1;
        step();
        arm = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL same_cycle_busy: got %b expected 1", busy); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL same_cycle_overflow: got %b expected 0", overflow); end
        step();
        step();
        trig_in = 1'b0;
        test_snapshot(1'b0, 17, 1'b0, "same_cycle");
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL same_cycle_overflow_end: got %b expected 0", overflow); end
    endtask

    task automatic test_abort();
        int            e_beat;
        int            got;
        logic [DW-1:0] got_d[$];
        arm = 1'b1;
        step();
        arm = 1'b0;
        repeat (29) step();
        trig_in = 1'b1;
        e_beat  = beat_idx;
        got     = 0;
        for (int c = 0; c < 200 && got < 7; c++) begin
            if (c == 1) trig_in = 1'b0;
            if (m_if.tvalid && m_if.tready) begin
                got_d.push_back(m_if.tdata);
                got++;
            end
            step();
        end
        trig_in = 1'b0;
        n_cmp++; if (got !== 7) begin n_fail++; $display("FAIL abort_prefix_count: got %0d expected 7", got); end
`ifdef ADC_CAPTURE_TIMESTAMP_EN
        for (int i = 1; i < got_d.size(); i++) begin
            n_cmp++; if (got_d[i] !== DW'(e_beat + POST - (DEPTH - 1) + i - 1)) begin n_fail++; $display("FAIL abort_data[%0d]: got %0h expected %0h", i, got_d[i], DW'(e_beat + POST - (DEPTH - 1) + i - 1)); end
        end
`else
        for (int i = 0; i < got_d.size(); i++) begin
            n_cmp++; if (got_d[i] !== DW'(e_beat + POST - (DEPTH - 1) + i)) begin n_fail++; $display("FAIL abort_data[%0d]: got %0h expected %0h", i, got_d[i], DW'(e_beat + POST - (DEPTH - 1) + i)); end
        end
`endif
        rst_n = 1'b0;                   // asynchronous, mid-cycle
        #1;
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL abort_tvalid: got %b expected 0", m_if.tvalid); end
        n_cmp++; if (m_if.tlast !== 1'b0) begin n_fail++; $display("FAIL abort_tlast: got %b expected 0", m_if.tlast); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", done); end
        step();
        step();
        rst_n = 1'b1;
        cyc   = 0;
        step();
        test_snapshot(1'b1, 25, 1'b0, "after_abort");
    endtask

`ifdef ADC_CAPTURE_TIMESTAMP_EN
    task automatic test_timestamp();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        cyc   = 0;
        step();
        // Trigger edge lands exactly on counter value 100.
        test_snapshot(1'b1, 100 - int'(cyc), 1'b0, "timestamp");
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_arm_trig_same_cycle();
        test_abort();
`ifdef ADC_CAPTURE_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_adc_capture_buffer
`default_nettype wire
